// File: rtl/rgb_status_pkg.sv
// Shared state codes and colour indices for the number-game status LED driver.
package rgb_status_pkg;

    typedef enum logic [1:0] {
        ST_GEN = 2'd0,
        ST_OK  = 2'd1,
        ST_ERR = 2'd2
    } state_e;

    localparam int unsigned COL_RED     = 32'd0;
    localparam int unsigned COL_GREEN   = 32'd1;
    localparam int unsigned COL_BLUE    = 32'd2;
    localparam int unsigned NUM_COLOURS = 32'd3;

endpackage

// File: rtl/rgb_pwm_gen.sv
// Prescaled PWM generator; the duty shadow only reloads on the period wrap so pulses are never cut short.
module rgb_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                pwm_on
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_FULL = {PWM_BITS{1'b1}};

    logic [PS_W-1:0]     presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] shadow_r;
    logic                tick_s;

    assign tick_s = (presc_r == PS_LAST);

    // Prescaler: one PWM tick every PRESCALE clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PS_W{1'b0}};
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    // PWM counter wraps naturally; duty is captured only at the wrap tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            shadow_r  <= PWM_FULL;
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + 1'b1;
            if (pwm_cnt_r == PWM_FULL) begin
                shadow_r <= brightness;
            end
        end
    end

    // All-ones means solid on, otherwise a compare against the running count
    assign pwm_on = (shadow_r == PWM_FULL) || (pwm_cnt_r < shadow_r);

endmodule

// File: rtl/rgb_status_pwm.sv
// Status LED driver: blue while generating, green on match, blinking red on mismatch,
// each result held for a fixed time, all dimmed by PWM and fanned out to NUM_LEDS LEDs.
module rgb_status_pwm
    import rgb_status_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                match,
    input  logic                not_match,
    input  logic                clear,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] rgb_red,
    output logic [NUM_LEDS-1:0] rgb_green,
    output logic [NUM_LEDS-1:0] rgb_blue,
    output logic [1:0]          state_o
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES);
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_e                 state_r, state_nxt_s;
    logic [HOLD_W-1:0]      hold_r, hold_nxt_s;
    logic                   err_entry_s;
    logic [BLINK_W-1:0]     blink_cnt_r;
    logic                   blink_phase_r;
    logic                   pwm_on_s;
    logic [NUM_COLOURS-1:0] colour_s;

    rgb_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .pwm_on     (pwm_on_s)
    );

    // Next-state and hold timer; clear beats match beats not_match
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        err_entry_s = 1'b0;
        if (clear) begin
            state_nxt_s = ST_GEN;
            hold_nxt_s  = {HOLD_W{1'b0}};
        end else if (match) begin
            state_nxt_s = ST_OK;
            hold_nxt_s  = HOLD_LOAD;
        end else if (not_match) begin
            state_nxt_s = ST_ERR;
            hold_nxt_s  = HOLD_LOAD;
            err_entry_s = 1'b1;
        end else begin
            case (state_r)
                ST_OK, ST_ERR: begin
                    if (hold_r == {HOLD_W{1'b0}}) begin
                        state_nxt_s = ST_GEN;
                    end else begin
                        hold_nxt_s = hold_r - 1'b1;
                    end
                end
                ST_GEN: begin
                    state_nxt_s = ST_GEN;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
                default: begin
                    state_nxt_s = ST_GEN;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // State and hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_GEN;
            hold_r  <= {HOLD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Blink timer restarts on every ERR entry and idles at phase-on outside ERR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (err_entry_s || (state_nxt_s != ST_ERR)) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
        end
    end

    // Colour selection from the current state; only one can be active
    always_comb begin
        colour_s            = {NUM_COLOURS{1'b0}};
        colour_s[COL_RED]   = (state_r == ST_ERR) && pwm_on_s && blink_phase_r;
        colour_s[COL_GREEN] = (state_r == ST_OK) && pwm_on_s;
        colour_s[COL_BLUE]  = (state_r == ST_GEN) && pwm_on_s;
    end

    // Output register, one clock behind the state/PWM update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_red   <= {NUM_LEDS{1'b0}};
            rgb_green <= {NUM_LEDS{1'b0}};
            rgb_blue  <= {NUM_LEDS{1'b0}};
        end else begin
            rgb_red   <= {NUM_LEDS{colour_s[COL_RED]}};
            rgb_green <= {NUM_LEDS{colour_s[COL_GREEN]}};
            rgb_blue  <= {NUM_LEDS{colour_s[COL_BLUE]}};
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_rgb_status_pwm.sv
// Bench for rgb_status_pwm: directed table, PWM period counts, reset abort and random run
// against a cycle-count based reference model.
module tb_rgb_status_pwm;

    localparam int NL    = 2;
    localparam int PB    = 4;
    localparam int PS    = 1;
    localparam int HOLD  = 20;
    localparam int BLINK = 5;
    localparam int PER   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          match, not_match, clear;
    logic [PB-1:0] brightness;
    logic [NL-1:0] rgb_red, rgb_green, rgb_blue;
    logic [1:0]    state_o;

    int checks   = 0;
    int failures = 0;

    // Model: state 0/1/2, edge index of last result entry, edges since reset, duty shadow
    int m_state, m_entry, m_k, m_shadow;
    logic [1:0] e_r, e_g, e_b, e_st;

    typedef struct {
        logic       m;
        logic       nm;
        logic       cl;
        int         n;
        logic [1:0] st;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } vec_t;

    vec_t tbl [0:20];

    rgb_status_pwm #(
        .NUM_LEDS     (NL),
        .PWM_BITS     (PB),
        .PRESCALE     (PS),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .match      (match),
        .not_match  (not_match),
        .clear      (clear),
        .brightness (brightness),
        .rgb_red    (rgb_red),
        .rgb_green  (rgb_green),
        .rgb_blue   (rgb_blue),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_entry  = 0;
        m_k      = 0;
        m_shadow = PER - 1;
        e_r = 2'b00; e_g = 2'b00; e_b = 2'b00; e_st = 2'b00;
    endtask

    // One clock edge of the reference: outputs reflect the state before the edge
    task automatic model_edge();
        int cnt;
        bit on, ph;
        cnt = (m_k / PS) % PER;
        on  = (m_shadow == PER - 1) || (cnt < m_shadow);
        ph  = (((m_k - m_entry) / BLINK) % 2) == 0;
        e_b = (m_state == 0 && on)       ? 2'b11 : 2'b00;
        e_g = (m_state == 1 && on)       ? 2'b11 : 2'b00;
        e_r = (m_state == 2 && on && ph) ? 2'b11 : 2'b00;
        m_k++;
        if (m_k % (PS * PER) == 0) m_shadow = int'(brightness);
        if (clear) m_state = 0;
        else if (match) begin m_state = 1; m_entry = m_k; end
        else if (not_match) begin m_state = 2; m_entry = m_k; end
        else if (m_state != 0 && (m_k - m_entry) == HOLD) m_state = 0;
        e_st = 2'(m_state);
    endtask

    task automatic cycle(input logic m, input logic nm, input logic cl);
        match = m; not_match = nm; clear = cl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("state_o", state_o, e_st);
        chk("rgb_red", rgb_red, e_r);
        chk("rgb_green", rgb_green, e_g);
        chk("rgb_blue", rgb_blue, e_b);
    endtask

    initial begin
        int ones;
        // {match, not_match, clear, cycles, state_o, red, green, blue} after the segment
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3,  2'd0, 2'b00, 2'b00, 2'b11};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,  2'd1, 2'b00, 2'b00, 2'b11};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  2'd1, 2'b00, 2'b11, 2'b00};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4,  2'd1, 2'b00, 2'b11, 2'b00};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1,  2'd1, 2'b00, 2'b11, 2'b00};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 19, 2'd1, 2'b00, 2'b11, 2'b00};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1,  2'd0, 2'b00, 2'b11, 2'b00};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,  2'd0, 2'b00, 2'b00, 2'b11};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1,  2'd2, 2'b00, 2'b00, 2'b11};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1,  2'd2, 2'b11, 2'b00, 2'b00};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4,  2'd2, 2'b11, 2'b00, 2'b00};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1,  2'd2, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 5,  2'd2, 2'b11, 2'b00, 2'b00};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8,  2'd2, 2'b00, 2'b00, 2'b00};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1,  2'd0, 2'b00, 2'b00, 2'b00};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1,  2'd0, 2'b00, 2'b00, 2'b11};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1,  2'd1, 2'b00, 2'b00, 2'b11};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2,  2'd1, 2'b00, 2'b11, 2'b00};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1,  2'd0, 2'b00, 2'b11, 2'b00};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1,  2'd0, 2'b00, 2'b00, 2'b11};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1,  2'd0, 2'b00, 2'b00, 2'b11};

        rst = 1'b1; match = 1'b0; not_match = 1'b0; clear = 1'b0; brightness = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", state_o, 2'd0);
        chk("reset_red", rgb_red, 2'b00);
        chk("reset_green", rgb_green, 2'b00);
        chk("reset_blue", rgb_blue, 2'b00);
        rst = 1'b0;
        model_reset();

        // Directed table at full brightness
        for (int i = 0; i <= 20; i++) begin
            for (int j = 0; j < tbl[i].n; j++) cycle(tbl[i].m, tbl[i].nm, tbl[i].cl);
            chk($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
            chk($sformatf("tbl%0d_red", i), rgb_red, tbl[i].r);
            chk($sformatf("tbl%0d_green", i), rgb_green, tbl[i].g);
            chk($sformatf("tbl%0d_blue", i), rgb_blue, tbl[i].b);
        end

        // Duty 4, change to 12 mid-period: current period keeps 4, next is 12
        brightness = 4'd4;
        for (int j = 0; j < PER && (m_k % PER) != 0; j++) cycle(1'b0, 1'b0, 1'b0);
        ones = 0;
        for (int j = 0; j < PER; j++) begin
            if (j == 8) brightness = 4'd12;
            cycle(1'b0, 1'b0, 1'b0);
            if (rgb_blue == 2'b11) ones++;
        end
        chk_int("pwm_duty4", ones, 4);
        ones = 0;
        for (int j = 0; j < PER; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (rgb_blue == 2'b11) ones++;
        end
        chk_int("pwm_duty12", ones, 12);
        brightness = 4'd0;
        for (int j = 0; j < PER; j++) cycle(1'b0, 1'b0, 1'b0);
        ones = 0;
        for (int j = 0; j < PER; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (rgb_blue != 2'b00) ones++;
        end
        chk_int("pwm_duty0", ones, 0);

        // Async reset in the middle of a mismatch display
        brightness = 4'hF;
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 1'b0);
        chk("pre_rst_err", state_o, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", state_o, 2'd0);
        chk("async_red", rgb_red, 2'b00);
        chk("async_green", rgb_green, 2'b00);
        chk("async_blue", rgb_blue, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_blue", rgb_blue, 2'b11);
        for (int j = 0; j < 45; j++) cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_idle", state_o, 2'd0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) brightness = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
